hash_cash_ctrl: RTL

Request sequencer for the `hash_cash` CAM cache. It accepts one READ, WRITE, DELETE or UPDATE request at a time over a valid/ready handshake. Each request is converted into a probe plus an action sequence on the cache ports, so duplicate keys are never written and writes never go into a full cache. A held valid/ready response channel returns read data and a status code. The parent instantiates this block beside `hash_cash`, and both share `clk` and `reset`.

---
 rtl/hash_cash_pkg.sv | 32 +++
 rtl/hash_cash_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/hash_cash_pkg.sv
// Shared types for the hash_cash request sequencer: op and status codes,
// FSM state encoding and the occupancy width helper.
package hash_cash_pkg;

  typedef enum logic [1:0] {
    OP_READ   = 2'd0,
    OP_WRITE  = 2'd1,
    OP_DELETE = 2'd2,
    OP_UPDATE = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    STS_OK   = 2'd0,
    STS_MISS = 2'd1,
    STS_DUP  = 2'd2,
    STS_FULL = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PROBE  = 3'd1,
    ST_DELETE = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  // Counter width able to hold every value 0..mem_size inclusive.
  function automatic int OCC_W(input int mem_size);
    return $clog2(mem_size + 1);
  endfunction

endpackage

// File: rtl/hash_cash_ctrl.sv
// Request sequencer in front of the hash_cash CAM: probe, then delete/write.
// Define HASH_CASH_CTRL_UPDATE_EN for in-place UPDATE; otherwise UPDATE acts as WRITE.
//
// state  | meaning
// IDLE   | ready for a request
// PROBE  | CAM lookup of latched key, decision at end of cycle
// DELETE | remove latched key from CAM
// WRITE  | insert latched key/data into CAM
// RESP   | response held until resp_ready
module hash_cash_ctrl
  import hash_cash_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int KEY_WIDTH  = 32,
  parameter int MEM_SIZE   = 128
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [1:0]                   req_op,
  input  logic [KEY_WIDTH-1:0]         req_key,
  input  logic [DATA_WIDTH-1:0]        req_data,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [1:0]                   resp_status,
  output logic [DATA_WIDTH-1:0]        resp_data,
  output logic [OCC_W(MEM_SIZE)-1:0]   occupancy,
  output logic                         full,
  output logic                         cam_cs,
  output logic                         cam_we,
  output logic                         cam_read_en,
  output logic                         cam_del,
  output logic [KEY_WIDTH-1:0]         cam_key_read,
  output logic [KEY_WIDTH-1:0]         cam_key_write,
  output logic [DATA_WIDTH-1:0]        cam_data_in,
  input  logic [DATA_WIDTH-1:0]        cam_data_out,
  input  logic                         cam_valid,
  input  logic [1:0]                   cam_error
);

  localparam int              OW      = OCC_W(MEM_SIZE);
  localparam logic [OW-1:0]   OCC_MAX = OW'(MEM_SIZE);

  state_e                  state_q, state_d;
  op_e                     op_q, op_d;
  logic [KEY_WIDTH-1:0]    key_q, key_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  status_e                 status_q, status_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [OW-1:0]           occ_q, occ_d;
  logic                    full_w;
  logic                    unused_err;

  assign unused_err = cam_error[1];
  assign full_w     = (occ_q == OCC_MAX);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    key_d    = key_q;
    data_d   = data_q;
    status_d = status_q;
    rdata_d  = rdata_q;
    occ_d    = occ_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
`ifdef HASH_CASH_CTRL_UPDATE_EN
          op_d = op_e'(req_op);
`else
          op_d = (req_op == OP_UPDATE) ? OP_WRITE : op_e'(req_op);
`endif
          key_d   = req_key;
          data_d  = req_data;
          state_d = ST_PROBE;
        end
      end
      ST_PROBE: begin
        status_d = STS_OK;
        rdata_d  = '0;
        state_d  = ST_RESP;
        case (op_q)
          OP_READ: begin
            if (cam_valid) rdata_d  = cam_data_out;
            else           status_d = STS_MISS;
          end
          OP_DELETE: begin
            if (cam_valid) state_d  = ST_DELETE;
            else           status_d = STS_MISS;
          end
`ifdef HASH_CASH_CTRL_UPDATE_EN
          OP_UPDATE: begin
            if (cam_valid)   state_d  = ST_DELETE;
            else if (full_w) status_d = STS_FULL;
            else             state_d  = ST_WRITE;
          end
`endif
          default: begin
            // A hit wins over full: duplicates report DUP even in a full cache.
            if (cam_valid)   status_d = STS_DUP;
            else if (full_w) status_d = STS_FULL;
            else             state_d  = ST_WRITE;
          end
        endcase
      end
      ST_DELETE: begin
        if (occ_q != '0) occ_d = occ_q - 1'b1;
        status_d = STS_OK;
        state_d  = ST_RESP;
`ifdef HASH_CASH_CTRL_UPDATE_EN
        if (op_q == OP_UPDATE) state_d = ST_WRITE;
`endif
      end
      ST_WRITE: begin
        if (!full_w) occ_d = occ_q + 1'b1;
        status_d = STS_OK;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_READ;
      key_q    <= '0;
      data_q   <= '0;
      status_q <= STS_OK;
      rdata_q  <= '0;
      occ_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      key_q    <= key_d;
      data_q   <= data_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
      occ_q    <= occ_d;
      if (state_q == ST_WRITE) assert (!cam_error[0]);
    end
  end

  assign req_ready     = (state_q == ST_IDLE);
  assign resp_valid    = (state_q == ST_RESP);
  assign resp_status   = status_q;
  assign resp_data     = rdata_q;
  assign occupancy     = occ_q;
  assign full          = full_w;
  assign cam_read_en   = (state_q == ST_PROBE);
  assign cam_del       = (state_q == ST_DELETE);
  assign cam_we        = (state_q == ST_WRITE);
  assign cam_cs        = cam_read_en | cam_del | cam_we;
  assign cam_key_read  = cam_read_en ? key_q : '0;
  assign cam_key_write = (cam_del | cam_we) ? key_q : '0;
  assign cam_data_in   = cam_we ? data_q : '0;

endmodule
